// File: rtl/traffic_ctrl_multi_pkg.sv
// Shared encodings, duration legality checks and demand-aware next-phase selection
// for the multi-approach traffic controller.
package traffic_pkg;

    localparam logic [1:0] ST_ALLRED = 2'b00;
    localparam logic [1:0] ST_GREEN  = 2'b01;
    localparam logic [1:0] ST_YELLOW = 2'b10;
    localparam logic [1:0] ST_FLASH  = 2'b11;

    function automatic bit dur_ok(input int dur, input int width);
        return (dur >= 1) && (dur <= 99) && (dur < (1 << width));
    endfunction

    // Scan cur+1 .. cur+n (mod n); the current approach is considered last.
    function automatic logic [1:0] next_phase(input logic [1:0] cur, input logic [3:0] dmd,
                                              input int n);
        logic [1:0] sel;
        logic       found;
        int         idx;
        idx   = (int'(cur) + 1) % n;
        sel   = idx[1:0];
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = (int'(cur) + k) % n;
            if (k <= n && !found && dmd[idx[1:0]]) begin
                sel   = idx[1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/traffic_ctrl_multi_if.sv
// Sensor/mode inputs and lamp/countdown outputs of the traffic controller.
// slave is the controller side, master is the environment side.
interface traffic_ctrl_multi_if #(
    parameter int N_DIR = 2,
    parameter int CNT_W = 7
);
    logic             flash_en;
    logic [N_DIR-1:0] demand;
    logic             tick;
    logic [1:0]       state;
    logic [1:0]       phase;
    logic [N_DIR-1:0] lamp_r;
    logic [N_DIR-1:0] lamp_y;
    logic [N_DIR-1:0] lamp_g;
    logic [CNT_W-1:0] remain;
    logic [3:0]       remain_tens;
    logic [3:0]       remain_ones;

    modport slave (
        input  flash_en, demand,
        output tick, state, phase, lamp_r, lamp_y, lamp_g, remain, remain_tens, remain_ones
    );

    modport master (
        output flash_en, demand,
        input  tick, state, phase, lamp_r, lamp_y, lamp_g, remain, remain_tens, remain_ones
    );
endinterface

// File: rtl/traffic_ctrl_multi_tick_gen.sv
// Free-running prescaler producing a one-cycle enable every TICK_DIV clocks.
// The enable is high while the count sits at TICK_DIV-1; no derived clock.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RSTn,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == CW'(TICK_DIV - 1));
endmodule

// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic controller: round-robin greens with one-shot extension and flash mode.
// State advances only on 1 s ticks; lamps/countdown are registered, BCD lags remain by one clock.
import traffic_pkg::*;

module traffic_ctrl_multi #(
    parameter int N_DIR    = 2,
    parameter int CNT_W    = 7,
    parameter int TICK_DIV = 50_000_000,
    parameter int GREEN_T  = 25,
    parameter int EXT_T    = 10,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 2
) (
    input logic               CLK,
    input logic               RSTn,
    traffic_ctrl_multi_if.slave bus
);
    if (!(N_DIR >= 2 && N_DIR <= 4 && dur_ok(GREEN_T, CNT_W) && dur_ok(EXT_T, CNT_W) &&
          dur_ok(YELLOW_T, CNT_W) && dur_ok(ALLRED_T, CNT_W))) begin : g_bad_param
        $error("traffic_ctrl_multi: N_DIR or a duration is out of range");
    end

    logic             tick;
    logic [1:0]       state, state_nxt;
    logic [1:0]       phase, phase_nxt;
    logic [CNT_W-1:0] remain, remain_nxt;
    logic             ext_used, ext_nxt;
    logic             flash_bit, flash_nxt;
    logic [N_DIR-1:0] lamp_r, lamp_y, lamp_g;
    logic [N_DIR-1:0] lamp_r_nxt, lamp_y_nxt, lamp_g_nxt;
    logic [3:0]       tens, ones;
    logic [3:0]       dmd4;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK  (CLK),
        .RSTn (RSTn),
        .tick (tick)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_ALLRED;
            phase     <= 2'(N_DIR - 1);
            remain    <= CNT_W'(ALLRED_T);
            ext_used  <= 1'b0;
            flash_bit <= 1'b0;
            lamp_r    <= '1;
            lamp_y    <= '0;
            lamp_g    <= '0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            remain    <= remain_nxt;
            ext_used  <= ext_nxt;
            flash_bit <= flash_nxt;
            lamp_r    <= lamp_r_nxt;
            lamp_y    <= lamp_y_nxt;
            lamp_g    <= lamp_g_nxt;
        end
    end

    always_comb begin
        dmd4       = 4'(bus.demand);
        state_nxt  = state;
        phase_nxt  = phase;
        remain_nxt = remain;
        ext_nxt    = ext_used;
        flash_nxt  = flash_bit;
        if (tick) begin
            // Flash request overrides any expiry landing on the same tick.
            if (bus.flash_en) begin
                state_nxt  = ST_FLASH;
                remain_nxt = '0;
                flash_nxt  = ~flash_bit;
            end else if (state == ST_FLASH) begin
                state_nxt  = ST_ALLRED;
                remain_nxt = CNT_W'(ALLRED_T);
            end else if (remain > CNT_W'(1)) begin
                remain_nxt = remain - CNT_W'(1);
            end else begin
                case (state)
                    ST_ALLRED: begin
                        state_nxt  = ST_GREEN;
                        phase_nxt  = next_phase(phase, dmd4, N_DIR);
                        remain_nxt = CNT_W'(GREEN_T);
                        ext_nxt    = 1'b0;
                    end
                    ST_GREEN: begin
                        if (!ext_used && bus.demand == (N_DIR'(1) << phase)) begin
                            remain_nxt = CNT_W'(EXT_T);
                            ext_nxt    = 1'b1;
                        end else begin
                            state_nxt  = ST_YELLOW;
                            remain_nxt = CNT_W'(YELLOW_T);
                        end
                    end
                    ST_YELLOW: begin
                        state_nxt  = ST_ALLRED;
                        remain_nxt = CNT_W'(ALLRED_T);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        lamp_r_nxt = '1;
        lamp_y_nxt = '0;
        lamp_g_nxt = '0;
        case (state_nxt)
            ST_GREEN: begin
                lamp_g_nxt[phase_nxt] = 1'b1;
                lamp_r_nxt[phase_nxt] = 1'b0;
            end
            ST_YELLOW: begin
                lamp_y_nxt[phase_nxt] = 1'b1;
                lamp_r_nxt[phase_nxt] = 1'b0;
            end
            ST_FLASH: begin
                lamp_r_nxt = '0;
                lamp_y_nxt = {N_DIR{flash_nxt}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tens <= 4'(ALLRED_T / 10);
            ones <= 4'(ALLRED_T % 10);
        end else begin
            tens <= 4'(int'(remain) / 10);
            ones <= 4'(int'(remain) % 10);
        end
    end

    assign bus.tick        = tick;
    assign bus.state       = state;
    assign bus.phase       = phase;
    assign bus.remain      = remain;
    assign bus.lamp_r      = lamp_r;
    assign bus.lamp_y      = lamp_y;
    assign bus.lamp_g      = lamp_g;
    assign bus.remain_tens = tens;
    assign bus.remain_ones = ones;
endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised multi-approach traffic-signal controller, the successor to the two-road AS/BS controller. It serves N_DIR approaches in demand-aware round-robin order, with one-shot green extension and a yellow-flash night mode. It generates its own 1 s tick as a clock enable rather than a derived clock. It exports per-approach lamps plus a binary and BCD countdown for the LCD/segment display layer.

## Interface
- N_DIR, 2: number of approaches, legal range 2..4.
- CNT_W, 7: countdown width.
- TICK_DIV, 50_000_000: CLK cycles per 1 s tick.
- GREEN_T, 25: base green seconds.
- EXT_T, 10: one-shot green extension seconds.
- YELLOW_T, 5: yellow seconds.
- ALLRED_T, 2: all-red clearance seconds.
- CLK  in  1  system clock (50 MHz); single clock domain.
- RSTn  in  1  reset; asynchronous assert, active-low.
- flash_en  in  1  night mode request; synchronous to CLK, sampled only on ticks.
- demand  in  N_DIR  vehicle sensors; bit i = approach i waiting; sampled only on ticks.
- tick  out  1  one-cycle pulse every TICK_DIV cycles.
- state  out  2  ALLRED=00, GREEN=01, YELLOW=10, FLASH=11.
- phase  out  2  index of the approach owning the current/last green.
- lamp_r, lamp_y, lamp_g  out  N_DIR each  per-approach lamps, one-hot per approach.
- remain  out  CNT_W  seconds left in current interval.
- remain_tens, remain_ones  out  4 each  BCD of remain.

## Operation
- Reset values:
  - state=ALLRED, phase=N_DIR-1, remain=ALLRED_T, tick=0, prescaler=0, ext_used=0, flash bit=0.
  - lamp_r=all 1, lamp_y=0, lamp_g=0.
  - BCD equals BCD(ALLRED_T).
- Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1.
- All FSM/countdown updates happen only in tick cycles.
- Countdown, on tick, when remain>1: remain-1. An interval of T seconds therefore lasts exactly T ticks.
- Transitions, on tick, when remain==1:
  - ALLRED -> GREEN. New phase = first index scanning (phase+1)..(phase+N_DIR) mod N_DIR with demand high. If no bit is high, new phase = (phase+1) mod N_DIR. Load GREEN_T; ext_used=0.
  - GREEN -> GREEN if demand[phase]=1, no other demand bit set, and ext_used=0. Load EXT_T; ext_used=1.
  - GREEN -> YELLOW otherwise. Load YELLOW_T.
  - YELLOW -> ALLRED. Load ALLRED_T.
- Flash mode:
  - flash_en=1 on any tick, from any state and any remain: go to FLASH, remain=0, flash bit toggles. This overrides the normal transition.
  - In FLASH, each tick toggles the flash bit.
  - flash_en=0 on a tick while in FLASH: go to ALLRED, load ALLRED_T, phase unchanged.
- Lamps:
  - GREEN: lamp_g[phase]=1.
  - YELLOW: lamp_y[phase]=1.
  - All other approaches red.
  - ALLRED: all red.
  - FLASH: lamp_y = {N_DIR{flash bit}}, red/green all 0.
- Arithmetic: all durations must be 1..99 and must fit CNT_W; elaboration fails otherwise. tens = remain/10, ones = remain%10.

## Timing
- state, phase, remain and lamps are registered. They change in the cycle after the tick cycle (same edge that ends tick).
- BCD outputs are registered from remain, so they lag remain by one CLK cycle.
- The prescaler is free-running and is never reset by mode changes.
- RSTn low mid-interval: all outputs return to reset values immediately (asynchronous), including mid-FLASH.
- A demand change between ticks is invisible. Only the value present in the tick cycle matters.
- Simultaneous expiry and flash_en in the same tick: FLASH wins.

## Structure
- Package traffic_pkg holds:
  - state encoding localparams.
  - the duration range checks.
  - a function computing next-phase selection from (phase, demand).
- Sub-module tick_gen (params TICK_DIV; ports CLK, RSTn, tick) implements the prescaler as an enable. It produces no derived clock.
- BCD split and lamp decode stay in the top module.

## Test plan
Bench parameters: N_DIR=3, TICK_DIV=4, GREEN_T=3, EXT_T=2, YELLOW_T=2, ALLRED_T=1.
- Release reset, demand=000 -> tick every 4 cycles. Sequence is G0(3) Y0(2) R(1) G1(3) Y1(2) R(1) G2 ... G0. remain goes 3,2,1 in GREEN.
- demand=100 held from reset -> G2 is selected first; skip order 2,2,2 (same approach re-served after ALLRED). Extension 2 s is applied once per green, so green totals 5 ticks.
- In G0 with demand=001 then demand=011 before expiry -> no extension. Y0 follows, then G1.
- flash_en=1 mid-GREEN at remain=2 -> FLASH on next tick. lamp_y alternates 111/000 per tick, lamp_r=lamp_g=0, remain=0. Release -> ALLRED, remain=1, then green of the next approach after phase.
- Assert RSTn low for 1 cycle mid-YELLOW -> all outputs at reset values immediately. First green afterwards is approach 0.
- Set GREEN_T=15 -> remain_tens/ones show 1/5, 1/4, ..., 0/1, each one cycle after remain.
